mul8_seq: RTL

- Sequential shift-add unsigned multiplier that sits directly upstream of the 8-bit datapath registers (reg8).
- Takes two operands on a START handshake and computes the full 2W-bit product over W cycles.
- Drives a write-back stream (data, write-enable, byte select) into reg8 instances: low byte first, then high byte.
- Gives the CPU a multi-cycle MUL execution stage without a combinational array multiplier.

---
 rtl/mul8_seq_pkg.sv | 17 +
 rtl/mul8_seq_add_w.sv | 13 +
 rtl/mul8_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mul8_seq_pkg.sv
// Shared CPU definitions for the multi-cycle MUL stage: state encoding,
// write-back byte select encoding and the default datapath width.
package mul8_seq_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WB_LO = 2'd2,
    ST_WB_HI = 2'd3
  } state_t;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/mul8_seq_add_w.sv
// WIDTH-bit unsigned adder with carry-out; reused by the ALU.
module add_w #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mul8_seq.sv
// Shift-add unsigned multiplier: WIDTH iterations, then the product is
// streamed out low byte first, high byte second, toward the reg8 pair.
module mul8_seq
  import mul8_seq_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] P,
  output logic [WIDTH-1:0]   WB_D,
  output logic               WB_WE,
  output logic               WB_SEL
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t               state_r;
  logic [WIDTH-1:0]     mcand_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [2*WIDTH-1:0]   p_r;
  logic [WIDTH-1:0]     wb_d_r;
  logic                 wb_we_r;
  logic                 wb_sel_r;
  logic                 busy_r;
  logic                 done_r;

  logic [WIDTH-1:0]     addend_s;
  logic [WIDTH-1:0]     sum_s;
  logic                 carry_s;
  logic [2*WIDTH-1:0]   prod_next_s;

  // Multiplicand is added only when the current multiplier bit is set.
  always_comb begin
    addend_s = {WIDTH{1'b0}};
    if (prod_r[0]) begin
      addend_s = mcand_r;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
  end

  add_w #(.WIDTH(WIDTH)) u_add (
    .a    (prod_r[2*WIDTH-1:WIDTH]),
    .b    (addend_s),
    .sum  (sum_s),
    .cout (carry_s)
  );

  // The carry becomes the new MSB as the partial product shifts right.
  assign prod_next_s = {carry_s, sum_s, prod_r[WIDTH-1:1]};

  // Control FSM, datapath registers and registered Moore outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      mcand_r  <= {WIDTH{1'b0}};
      prod_r   <= {(2*WIDTH){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      p_r      <= {(2*WIDTH){1'b0}};
      wb_d_r   <= {WIDTH{1'b0}};
      wb_we_r  <= 1'b0;
      wb_sel_r <= SEL_LO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (START) begin
            mcand_r <= A;
            prod_r  <= {{WIDTH{1'b0}}, B};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          prod_r <= prod_next_s;
          cnt_r  <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_LAST) begin
            p_r      <= prod_next_s;
            wb_we_r  <= 1'b1;
            wb_sel_r <= SEL_LO;
            wb_d_r   <= prod_next_s[WIDTH-1:0];
            state_r  <= ST_WB_LO;
          end
        end
        ST_WB_LO: begin
          wb_we_r  <= 1'b1;
          wb_sel_r <= SEL_HI;
          wb_d_r   <= p_r[2*WIDTH-1:WIDTH];
          done_r   <= 1'b1;
          state_r  <= ST_WB_HI;
        end
        ST_WB_HI: begin
          wb_we_r  <= 1'b0;
          wb_sel_r <= SEL_LO;
          wb_d_r   <= {WIDTH{1'b0}};
          done_r   <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          wb_we_r  <= 1'b0;
          wb_sel_r <= SEL_LO;
          wb_d_r   <= {WIDTH{1'b0}};
          done_r   <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign P      = p_r;
  assign WB_D   = wb_d_r;
  assign WB_WE  = wb_we_r;
  assign WB_SEL = wb_sel_r;

endmodule
